// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and the HI/LO result payload.
package mdu_pkg;

  localparam int unsigned MDU_DATA_W = 32;
  localparam int unsigned MDU_OP_W   = 3;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  // Also used by the CTRLE decoder, so the encoding must stay fixed.
  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_MADD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [MDU_DATA_W-1:0] hi;
    logic [MDU_DATA_W-1:0] lo;
  } mdu_result_t;

  // Full-width product; operands are extended to 64 bits so the low 64 bits
  // of an unsigned multiply give the correct signed or unsigned result.
  function automatic logic [2*MDU_DATA_W-1:0] mdu_mul64(
    input logic [MDU_DATA_W-1:0] x,
    input logic [MDU_DATA_W-1:0] y,
    input logic                  is_signed
  );
    logic [2*MDU_DATA_W-1:0] xe;
    logic [2*MDU_DATA_W-1:0] ye;
    xe = {{MDU_DATA_W{is_signed & x[MDU_DATA_W-1]}}, x};
    ye = {{MDU_DATA_W{is_signed & y[MDU_DATA_W-1]}}, y};
    return xe * ye;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider: quotient truncated toward zero,
// remainder carries the dividend's sign; flags divide-by-zero.
module mdu_divider
  import mdu_pkg::*;
(
  input  logic [MDU_DATA_W-1:0] dividend,
  input  logic [MDU_DATA_W-1:0] divisor,
  input  logic                  is_signed,
  output logic [MDU_DATA_W-1:0] quotient,
  output logic [MDU_DATA_W-1:0] remainder,
  output logic                  div_by_zero
);

  logic                  dvd_neg;
  logic                  dvs_neg;
  logic [MDU_DATA_W-1:0] dvd_mag;
  logic [MDU_DATA_W-1:0] dvs_mag;
  logic [MDU_DATA_W-1:0] dvs_safe;
  logic [MDU_DATA_W-1:0] q_mag;
  logic [MDU_DATA_W-1:0] r_mag;

  // Magnitude divide then re-sign; 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    dvd_neg     = is_signed & dividend[MDU_DATA_W-1];
    dvs_neg     = is_signed & divisor[MDU_DATA_W-1];
    dvd_mag     = dvd_neg ? (MDU_DATA_W'(0) - dividend) : dividend;
    dvs_mag     = dvs_neg ? (MDU_DATA_W'(0) - divisor) : divisor;
    div_by_zero = (divisor == '0);
    dvs_safe    = div_by_zero ? MDU_DATA_W'(1) : dvs_mag;
    q_mag       = dvd_mag / dvs_safe;
    r_mag       = dvd_mag % dvs_safe;
    quotient    = (dvd_neg ^ dvs_neg) ? (MDU_DATA_W'(0) - q_mag) : q_mag;
    remainder   = dvd_neg ? (MDU_DATA_W'(0) - r_mag) : r_mag;
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Optional signed
// multiply-accumulate (op 7) is built only when MDU_MADD_EN is defined.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MDU_OP_W-1:0]   op,
  input  logic [MDU_DATA_W-1:0] a,
  input  logic [MDU_DATA_W-1:0] b,
  output logic                  busy,
  output logic [MDU_DATA_W-1:0] hi,
  output logic [MDU_DATA_W-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e            state;
  logic [CNT_W-1:0]      cnt;
  mdu_result_t           pending;
  logic                  pending_wr;

  logic [2*MDU_DATA_W-1:0] prod_s;
  logic [2*MDU_DATA_W-1:0] prod_u;
  logic [MDU_DATA_W-1:0]   div_q;
  logic [MDU_DATA_W-1:0]   div_r;
  logic                    div_zero;
  logic                    div_signed;

  assign prod_s     = mdu_mul64(a, b, 1'b1);
  assign prod_u     = mdu_mul64(a, b, 1'b0);
  assign div_signed = (op == MDU_DIV);

  mdu_divider u_divider (
    .dividend    (a),
    .divisor     (b),
    .is_signed   (div_signed),
    .quotient    (div_q),
    .remainder   (div_r),
    .div_by_zero (div_zero)
  );

  // Result is captured into pending at the start edge; HI/LO only change on
  // the final countdown edge, so an abandoned op never touches them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= MDU_IDLE;
      cnt        <= '0;
      pending    <= '0;
      pending_wr <= 1'b0;
      busy       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            case (op)
              MDU_MULT: begin
                pending    <= prod_s;
                pending_wr <= 1'b1;
                cnt        <= CNT_W'(MULT_CYCLES);
                busy       <= 1'b1;
                state      <= MDU_RUN;
              end
              MDU_MULTU: begin
                pending    <= prod_u;
                pending_wr <= 1'b1;
                cnt        <= CNT_W'(MULT_CYCLES);
                busy       <= 1'b1;
                state      <= MDU_RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                pending.hi <= div_r;
                pending.lo <= div_q;
                pending_wr <= ~div_zero;
                cnt        <= CNT_W'(DIV_CYCLES);
                busy       <= 1'b1;
                state      <= MDU_RUN;
              end
              MDU_MTHI: hi <= a;
              MDU_MTLO: lo <= a;
`ifdef MDU_MADD_EN
              MDU_MADD: begin
                pending    <= {hi, lo} + prod_s;
                pending_wr <= 1'b1;
                cnt        <= CNT_W'(MULT_CYCLES);
                busy       <= 1'b1;
                state      <= MDU_RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        MDU_RUN: begin
          if (cnt == CNT_W'(1)) begin
            if (pending_wr) begin
              hi <= pending.hi;
              lo <= pending.lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= MDU_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule
